// File: rtl/data_from_transfer.sv
// data_from_transfer: receive-side frame assembler for the board-to-board
// score link. It collects 4-byte frames (ID, points hi, mid, lo) from the
// UART RX byte strobe and presents the last complete frame on registered
// outputs. Partial frames are dropped on an inter-byte timeout.
// Optional feature: define RX_HEADER_CHECK_EN to reject header bytes whose
// upper six bits are non-zero, so a misaligned stream resynchronises.
module data_from_transfer #(
  parameter int TIMEOUT_CYCLES = 650000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [1:0]  board_ID,
  output logic [23:0] points,
  output logic        frame_valid,
  output logic        frame_error,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pend_id;
  logic [7:0]       pend_hi;
  logic [7:0]       pend_mid;
  logic             commit;
  logic             error_next;
  logic             timeout;

  // Expiry is seen on the last idle cycle; a byte in that same cycle wins.
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples the values from before the edge.
    else        state <= state_next;
  end

  // Next-state logic, commit request and error strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    commit     = 1'b0;
    error_next = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done) begin
`ifdef RX_HEADER_CHECK_EN
          if (rx_data[7:2] != 6'd0) error_next = 1'b1;
          else                      state_next = B1;
`else
          state_next = B1;
`endif
        end
      end
      B1, B2: begin
        if (rx_done) begin
          state_next = (state == B1) ? B2 : B3;
        end else if (timeout) begin
          state_next = IDLE;
          error_next = 1'b1;
        end
      end
      B3: begin
        if (rx_done) begin
          state_next = IDLE;
          commit     = 1'b1;
        end else if (timeout) begin
          state_next = IDLE;
          error_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Inter-byte idle counter: runs only while a frame is partially held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cnt <= '0;
    else if (state == IDLE || rx_done || timeout) cnt <= '0;
    else                                        cnt <= cnt + CNT_W'(1);
  end

  // Pending bytes of the frame under assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_id  <= 2'b00;
      pend_hi  <= 8'h00;
      pend_mid <= 8'h00;
    end else if (rx_done) begin
      case (state)
        IDLE:    pend_id  <= rx_data[1:0];
        B1:      pend_hi  <= rx_data;
        B2:      pend_mid <= rx_data;
        default: ;
      endcase
    end
  end

  // Registered outputs: frame contents change only on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_ID    <= 2'b00;
      points      <= 24'h000000;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_cnt   <= 8'h00;
    end else begin
      frame_valid <= commit;
      frame_error <= error_next;
      if (commit) begin
        board_ID  <= pend_id;
        points    <= {pend_hi, pend_mid, rx_data};
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_from_transfer.sv
// Self-checking bench for data_from_transfer: a scoreboard queue holds the
// expected frame for every fourth byte sent; a negedge monitor pops and
// compares it on each frame_valid pulse and counts frame_error pulses.
module tb_data_from_transfer;

  localparam int T = 8;

  typedef struct packed {
    logic [1:0]  id;
    logic [23:0] pts;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [1:0]  board_ID;
  logic [23:0] points;
  logic        frame_valid;
  logic        frame_error;
  logic [7:0]  frame_cnt;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          err_seen = 0;
  int          exp_err  = 0;
  logic [7:0]  exp_cnt  = 8'h00;
  logic [1:0]  last_id  = 2'b00;
  logic [23:0] last_pts = 24'h0;

  data_from_transfer #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .board_ID    (board_ID),
    .points      (points),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: compare every frame_valid pulse with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_error) err_seen++;
      if (frame_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_frame_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_board_ID", 32'(board_ID), 32'(e.id));
          check("sb_points", 32'(points), 32'(e.pts));
          check("sb_frame_cnt", 32'(frame_cnt), 32'(e.cnt));
        end
      end
    end
  end

  // One byte: rx_done high across exactly one rising edge; returns #1 after it.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full frame sent back-to-back; expected result pushed before the last byte.
  task automatic send_frame(input logic [1:0] id, input logic [23:0] pts);
    exp_t e;
    exp_cnt  = exp_cnt + 8'd1;
    last_id  = id;
    last_pts = pts;
    e.id = id; e.pts = pts; e.cnt = exp_cnt;
    send_byte({6'd0, id});
    send_byte(pts[23:16]);
    send_byte(pts[15:8]);
    sb.push_back(e);
    send_byte(pts[7:0]);
  endtask

  initial begin
    int fire;
    exp_t e;
    // Reset state.
    #2;
    check("rst_board_ID", 32'(board_ID), 32'd0);
    check("rst_points", 32'(points), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Basic frame with exact one-cycle latency.
    send_frame(2'd2, 24'h123456);
    check("t1_valid_after_byte4", 32'(frame_valid), 32'd1);
    check("t1_board_ID", 32'(board_ID), 32'd2);
    check("t1_points", 32'(points), 32'h123456);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    idle(1);
    check("t1_valid_one_cycle", 32'(frame_valid), 32'd0);

    // Timeout after two bytes: error exactly T cycles after the last byte.
    send_byte(8'h01);
    send_byte(8'hAB);
    fire = 0;
    for (int k = 1; k <= T + 3; k++) begin
      @(posedge clk);
      #1;
      if (frame_error && fire == 0) fire = k;
    end
    exp_err++;
    check("to_fire_cycle", 32'(fire), 32'(T));
    check("to_board_ID_kept", 32'(board_ID), 32'(last_id));
    check("to_points_kept", 32'(points), 32'(last_pts));
    check("to_err_count", 32'(err_seen), 32'(exp_err));
    send_frame(2'd1, 24'h000007);
    idle(1);
    check("to_next_points", 32'(points), 32'h000007);

    // Byte on the exact expiry cycle is accepted, frame completes.
    e.id = 2'd3; e.pts = 24'hA1B2C3;
    send_byte({6'd0, e.id});
    idle(T - 1);
    send_byte(e.pts[23:16]);
    idle(T - 1);
    send_byte(e.pts[15:8]);
    idle(T - 1);
    exp_cnt = exp_cnt + 8'd1;
    e.cnt = exp_cnt;
    sb.push_back(e);
    last_id = e.id; last_pts = e.pts;
    send_byte(e.pts[7:0]);
    idle(2);
    check("exp_edge_points", 32'(points), 32'hA1B2C3);
    check("exp_edge_no_err", 32'(err_seen), 32'(exp_err));

    // Malformed header byte then a full frame.
    e.id = 2'd3;
`ifdef RX_HEADER_CHECK_EN
    e.pts = 24'hFFFFFF;
`else
    e.pts = 24'h03FFFF;
`endif
    exp_cnt = exp_cnt + 8'd1;
    e.cnt = exp_cnt;
    send_byte(8'hFF);
    send_byte(8'h03);
    send_byte(8'hFF);
    sb.push_back(e);
    send_byte(8'hFF);
    send_byte(8'hFF);
    idle(T + 3);
    // With the check: the 0xFF header is rejected. Without it: the trailing
    // 0xFF starts a partial frame that then times out. One error either way.
    exp_err++;
    check("hdr_board_ID", 32'(board_ID), 32'(e.id));
    check("hdr_points", 32'(points), 32'(e.pts));
    check("hdr_err_count", 32'(err_seen), 32'(exp_err));

    // Reset mid-frame: outputs clear, partial frame lost.
    send_byte(8'h02);
    send_byte(8'h55);
    rst_n = 1'b0;
    #1;
    check("mid_rst_board_ID", 32'(board_ID), 32'd0);
    check("mid_rst_points", 32'(points), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_valid", 32'(frame_valid), 32'd0);
    idle(2);
    rst_n = 1'b1;
    exp_cnt = 8'h00;
    idle(1);
    send_frame(2'd1, 24'h0A0B0C);
    idle(1);
    check("post_rst_points", 32'(points), 32'h0A0B0C);
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

    // 255 more frames: 256 since reset, so the counter wraps to zero.
    for (int i = 0; i < 255; i++) begin
      send_frame(2'($urandom_range(3)), 24'($urandom));
    end
    idle(2);
    check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
    check("wrap_points", 32'(points), 32'(last_pts));
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_err_count", 32'(err_seen), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
